// File: rtl/data_mem_responder_pkg.sv
// Shared load/store encodings, FSM states and request record for the data-memory responder.
// The controller (data_mem_responder) and datapath (mem_lane_align) both import this package.
package data_mem_responder_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef struct packed {
        logic        wr;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

    function automatic logic funct3_legal(input logic wr, input logic [2:0] funct3);
        if (wr) begin
            return (funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW);
        end
        return (funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW) ||
               (funct3 == F3_LBU) || (funct3 == F3_LHU);
    endfunction

    // Size lives in funct3[1:0] for both loads and stores.
    function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] byte_off);
        case (funct3[1:0])
            2'b01:   return byte_off[0];
            2'b10:   return byte_off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane datapath: extracts and extends load data from a memory word, and
// replicates store data across lanes with the matching byte-enable mask.
module mem_lane_align
    import data_mem_responder_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  byte_off_i,
    input  logic [31:0] rd_word_i,
    input  logic [31:0] st_data_i,
    output logic [31:0] ld_data_o,
    output logic [31:0] wr_word_o,
    output logic [3:0]  wr_be_o
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    assign lane_byte = rd_word_i[{byte_off_i, 3'b000} +: 8];
    assign lane_half = rd_word_i[{byte_off_i[1], 4'b0000} +: 16];

    always_comb begin
        case (funct3_i)
            F3_LB:   ld_data_o = {{24{lane_byte[7]}}, lane_byte};
            F3_LH:   ld_data_o = {{16{lane_half[15]}}, lane_half};
            F3_LW:   ld_data_o = rd_word_i;
            F3_LBU:  ld_data_o = {24'd0, lane_byte};
            F3_LHU:  ld_data_o = {16'd0, lane_half};
            default: ld_data_o = '0;
        endcase
    end

    // Store data is right-aligned; replicating it lets the mask alone pick the lanes.
    always_comb begin
        case (funct3_i[1:0])
            2'b00: begin
                wr_word_o = {4{st_data_i[7:0]}};
                wr_be_o   = 4'b0001 << byte_off_i;
            end
            2'b01: begin
                wr_word_o = {2{st_data_i[15:0]}};
                wr_be_o   = 4'b0011 << {byte_off_i[1], 1'b0};
            end
            2'b10: begin
                wr_word_o = st_data_i;
                wr_be_o   = 4'b1111;
            end
            default: begin
                wr_word_o = '0;
                wr_be_o   = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding data-memory responder: valid/ready request, fixed wait,
// then a held response. Memory access and error check happen on entry to RESP.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Req_Valid,
    output logic        Req_Ready,
    input  logic        Req_Write,
    input  logic [2:0]  Req_Funct3,
    input  logic [31:0] Req_Addr,
    input  logic [31:0] Req_WData,
    output logic        Rsp_Valid,
    input  logic        Rsp_Ready,
    output logic [31:0] Rsp_RData,
    output logic        Rsp_Err
);

    localparam int         AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] CNT_LOAD   = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
    localparam logic [29:0] WORD_LIMIT = 30'(DEPTH);

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    mem_req_t    req_q, req_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] mem_q [DEPTH];

    mem_req_t    acc;
    logic        enter_resp;
    logic        in_range;
    logic        access_err;
    logic        mem_we;
    logic [AW-1:0] idx;
    logic [31:0] rd_word;
    logic [31:0] ld_data;
    logic [31:0] wr_word;
    logic [3:0]  wr_be;

    // With WAIT_CYCLES=0 the access happens on the accept edge, before req_q is loaded.
    always_comb begin
        if (state_q == ST_IDLE) begin
            acc.wr     = Req_Write;
            acc.funct3 = Req_Funct3;
            acc.addr   = Req_Addr;
            acc.wdata  = Req_WData;
        end else begin
            acc = req_q;
        end
    end

    assign in_range   = acc.addr[31:2] < WORD_LIMIT;
    assign idx        = acc.addr[AW+1:2];
    assign rd_word    = in_range ? mem_q[idx] : '0;
    assign access_err = !in_range || !funct3_legal(acc.wr, acc.funct3) ||
                        misaligned(acc.funct3, acc.addr[1:0]);

    mem_lane_align u_lane_align (
        .funct3_i   (acc.funct3),
        .byte_off_i (acc.addr[1:0]),
        .rd_word_i  (rd_word),
        .st_data_i  (acc.wdata),
        .ld_data_o  (ld_data),
        .wr_word_o  (wr_word),
        .wr_be_o    (wr_be)
    );

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_d       = req_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        enter_resp  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (Req_Valid) begin
                    req_d = acc;
                    if (WAIT_CYCLES == 0) begin
                        state_d    = ST_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d    = ST_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (Rsp_Ready) begin
                    state_d     = ST_IDLE;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (enter_resp) begin
            rsp_err_d   = access_err;
            rsp_rdata_d = (access_err || acc.wr) ? 32'd0 : ld_data;
        end
    end

    assign mem_we = enter_resp && acc.wr && !access_err;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            req_q       <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // NOTE: the memory is reset word-by-word because the initiator relies on reading zeros after reset.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem_q[idx][8*b +: 8] <= wr_word[8*b +: 8];
                end
            end
        end
    end

    assign Req_Ready = (state_q == ST_IDLE);
    assign Rsp_Valid = (state_q == ST_RESP);
    assign Rsp_RData = rsp_rdata_q;
    assign Rsp_Err   = rsp_err_q;

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 64, number of 32-bit memory words.
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, extra cycles between request accept and response; legal range 0..15.
REQ-003 SHALL have port Clock  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port Req_Valid  input  1  request present.
REQ-006 SHALL have port Req_Ready  output  1  responder can accept a request.
REQ-007 SHALL have port Req_Write  input  1  1 = store, 0 = load.
REQ-008 SHALL have port Req_Funct3  input  3  access size and sign, RISC-V load/store encoding.
REQ-009 SHALL have port Req_Addr  input  32  byte address.
REQ-010 SHALL have port Req_WData  input  32  store data, right-aligned.
REQ-011 SHALL have port Rsp_Valid  output  1  response present.
REQ-012 SHALL have port Rsp_Ready  input  1  initiator accepts the response.
REQ-013 SHALL have port Rsp_RData  output  32  load data, extended to 32 bits; 0 for stores and errors.
REQ-014 SHALL have port Rsp_Err  output  1  access rejected.

Function
REQ-015 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE.
- In WAIT_CYCLES=0 configurations, the FSM SHALL skip WAIT and go IDLE -> RESP.
REQ-016 SHALL assert Req_Ready only in IDLE; a request is accepted on a rising edge with Req_Valid && Req_Ready.
- On acceptance, the block SHALL latch Write, Funct3, Addr and WData.
REQ-017 In WAIT, a 4-bit down-counter loaded with WAIT_CYCLES-1 SHALL decrement each cycle; the block SHALL enter RESP when the counter reaches 0.
REQ-018 Response timing:
- The memory access and error check SHALL occur on entry to RESP.
- Rsp_Valid SHALL assert the first cycle in RESP.
- Request-accept to Rsp_Valid latency SHALL be WAIT_CYCLES+1 cycles.
REQ-019 Rsp_Valid, Rsp_RData and Rsp_Err SHALL hold stable until the cycle with Rsp_Valid && Rsp_Ready; the FSM SHALL then return to IDLE.
- There is no request/response overlap: at most one access is outstanding.
REQ-020 Loads SHALL decode Funct3 as: 000 LB sign-extended, 001 LH sign-extended, 010 LW, 100 LBU zero-extended, 101 LHU zero-extended.
REQ-021 Stores SHALL decode Funct3 as: 000 SB, 001 SH, 010 SW.
- SB/SH SHALL write only the addressed byte lanes, leaving the other bytes unchanged.
REQ-022 Address mapping:
- Word index SHALL be Addr[31:2].
- Byte lane SHALL be Addr[1:0], little-endian.
REQ-023 Rsp_Err SHALL be 1, and no memory write SHALL occur, for any of:
- halfword access with Addr[0]=1;
- word access with Addr[1:0]!=0;
- Addr >= DEPTH*4;
- an illegal Funct3 (loads 011/110/111; stores 011 and above).
REQ-024 A store SHALL still produce a response (Rsp_RData=0) so the initiator always sees completion.
REQ-025 Changes on the Req_* inputs while not in IDLE SHALL be ignored.
- Rsp_Ready while Rsp_Valid=0 SHALL be ignored.
REQ-026 A load SHALL return data written by the immediately preceding accepted store to the same address (read-after-write).

Reset
REQ-027 While Reset=0, the block SHALL asynchronously set:
- FSM = IDLE;
- Req_Ready = 1 after release;
- Rsp_Valid = 0, Rsp_RData = 0, Rsp_Err = 0;
- counter = 0;
- all memory words = 0.
REQ-028 Reset asserted mid-access (WAIT or RESP) SHALL abort the access with no memory update and no response after release.

Structure
REQ-029 Funct3 load/store encodings and the FSM state enumeration SHALL reside in the shared processor package, reused by the controller and the datapath.
REQ-030 The byte/halfword extract-extend and byte-lane write-mask logic SHALL be one sub-module, mem_lane_align (combinational), instantiated once.

Verification
REQ-031 SW 0x12345678 @0x10, then LW @0x10 -> Rsp_RData=0x12345678, Rsp_Err=0; Rsp_Valid exactly WAIT_CYCLES+1 cycles after each accept.
REQ-032 SB 0xAB @0x13 over word 0x12345678 -> LW @0x10 = 0xAB345678; LB @0x13 = 0xFFFFFFAB; LBU @0x13 = 0x000000AB.
REQ-033 LH @0x11, LW @0x12, and SW @0x100 with DEPTH=64 -> Rsp_Err=1 and Rsp_RData=0 for each; a later LW @0x100-aligned in-range word is unchanged.
REQ-034 Hold Rsp_Ready=0 for 5 cycles during a response -> Rsp_Valid, Rsp_RData and Rsp_Err stay constant, Req_Ready=0, and a new Req_Valid is not accepted until one cycle after the Rsp_Ready handshake.
REQ-035 Assert Reset=0 during WAIT of SW 0xDEADBEEF @0x20 -> no Rsp_Valid after release; LW @0x20 returns 0x00000000.
REQ-036 WAIT_CYCLES=0 build: back-to-back LW with Rsp_Ready tied 1 -> one accept every 2 cycles, latency 1.
